fnv1a_hash_core: RTL and testbench

FNV1A_HASH_CORE -- requirements
Module: fnv1a_hash_core

---
 rtl/fnv1a_hash_core_pkg.sv | 15 +
 rtl/fnv1a_hash_core_round.sv | 20 ++
 rtl/fnv1a_hash_core.sv | 114 +++++++++++
 tb/tb_fnv1a_hash_core.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnv1a_hash_core_pkg.sv
// Shared definitions for the FNV-1a 32-bit hash core.
//   fnv32_offset_basis : initial hash value
//   fnv32_prime        : FNV-1a 32-bit multiplier
//   state_e            : absorb/emit controller states
package fnv1a_hash_core_pkg;

    localparam logic [31:0] FNV32_OFFSET_BASIS = 32'h811C9DC5;
    localparam logic [31:0] FNV32_PRIME        = 32'h01000193;

    typedef enum logic {
        StAbsorb = 1'b0,
        StEmit   = 1'b1
    } state_e;

endpackage

// File: rtl/fnv1a_hash_core_round.sv
// One combinational FNV-1a round: h_next = (h ^ data) * FNV32_PRIME mod 2^32.
//   h      : current hash value
//   data   : message byte to fold in
//   h_next : updated hash value
// The multiply is the fixed shift-add decomposition of the prime
// (2^24 + 2^8 + 2^7 + 2^4 + 2^1 + 2^0), so no multiplier is inferred.
module fnv1a_round (
    input  logic [31:0] h,
    input  logic [7:0]  data,
    output logic [31:0] h_next
);

    logic [31:0] x;

    always_comb begin
        x      = h ^ {24'h0, data};
        h_next = x + (x << 1) + (x << 4) + (x << 7) + (x << 8) + (x << 24);
    end

endmodule

// File: rtl/fnv1a_hash_core.sv
// Byte-serial FNV-1a 32-bit hash core.
// Absorbs one message byte per cycle, then emits the 4-byte digest over a
// valid/ready byte stream.
//   clk, rst_n           : clock, asynchronous active-low reset
//   clear_i              : synchronous abandon/restart, highest priority
//   in_valid/in_data/in_last/in_ready : message byte stream
//   flush_i              : end the message without a byte
//   out_valid/out_data/out_last/out_ready : digest byte stream
//   busy_o               : message in progress or digest pending
// Parameter MSB_FIRST selects digest byte order (1: bits[31:24] first).
module fnv1a_hash_core
    import fnv1a_hash_core_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       flush_i,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy_o
);

    state_e      state_q, state_d;
    logic [31:0] h_q, h_d;
    logic [1:0]  idx_q, idx_d;
    logic        dirty_q, dirty_d;
    logic [31:0] h_next;
    logic [1:0]  sel;
    logic        accept;

    fnv1a_round u_round (
        .h      (h_q),
        .data   (in_data),
        .h_next (h_next)
    );

    assign accept = in_valid & in_ready;

    // The hash register doubles as the digest while emitting: nothing is
    // absorbed in that state, so it holds the latched value.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        idx_d   = idx_q;
        dirty_d = dirty_q;
        if (clear_i) begin
            state_d = StAbsorb;
            h_d     = FNV32_OFFSET_BASIS;
            idx_d   = 2'd0;
            dirty_d = 1'b0;
        end else begin
            unique case (state_q)
                StAbsorb: begin
                    if (accept) begin
                        h_d     = h_next;
                        dirty_d = 1'b1;
                    end
                    if ((accept && in_last) || flush_i) begin
                        state_d = StEmit;
                        idx_d   = 2'd0;
                    end
                end
                StEmit: begin
                    if (out_ready) begin
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d = StAbsorb;
                            h_d     = FNV32_OFFSET_BASIS;
                            dirty_d = 1'b0;
                        end
                    end
                end
                default: state_d = StAbsorb;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAbsorb;
            h_q     <= FNV32_OFFSET_BASIS;
            idx_q   <= 2'd0;
            dirty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            idx_q   <= idx_d;
            dirty_q <= dirty_d;
        end
    end

    // Byte lane of the digest: MSB-first walks lanes 3..0, i.e. ~idx.
    assign sel = MSB_FIRST ? ~idx_q : idx_q;

    always_comb begin
        in_ready  = (state_q == StAbsorb);
        out_valid = (state_q == StEmit);
        out_last  = (state_q == StEmit) && (idx_q == 2'd3);
        out_data  = 8'h00;
        if (state_q == StEmit) begin
            out_data = h_q[{sel, 3'b000} +: 8];
        end
        busy_o = dirty_q | (state_q == StEmit);
    end

endmodule

// File: tb/tb_fnv1a_hash_core.sv
// Scoreboard bench: two cores (MSB-first and LSB-first) share all stimulus;
// expected digest bytes are queued by the stimulus, the monitor pops and
// compares on every output handshake.
module tb_fnv1a_hash_core;

    logic       clk;
    logic       rst_n;
    logic       clear_i;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       flush_i;
    logic       out_ready;
    logic       in_ready0, out_valid0, out_last0, busy0;
    logic       in_ready1, out_valid1, out_last1, busy1;
    logic [7:0] out_data0, out_data1;

    typedef struct packed {
        logic [7:0] msb;
        logic [7:0] lsb;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by stimulus

    fnv1a_hash_core #(.MSB_FIRST(1'b1)) u_dut_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear_i),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .flush_i   (flush_i),
        .in_ready  (in_ready0),
        .out_valid (out_valid0),
        .out_data  (out_data0),
        .out_last  (out_last0),
        .out_ready (out_ready),
        .busy_o    (busy0)
    );

    fnv1a_hash_core #(.MSB_FIRST(1'b0)) u_dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear_i),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .flush_i   (flush_i),
        .in_ready  (in_ready1),
        .out_valid (out_valid1),
        .out_data  (out_data1),
        .out_last  (out_last1),
        .out_ready (out_ready),
        .busy_o    (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_digest(input logic [31:0] d, input int nbytes);
        exp_t e;
        for (int k = 0; k < nbytes; k++) begin
            e.msb  = d[31 - 8 * k -: 8];
            e.lsb  = d[8 * k +: 8];
            e.last = (k == 3);
            exp_q.push_back(e);
        end
    endtask

    // Called just after a rising edge; the byte is taken on the next edge.
    task automatic send_byte(input logic [7:0] b, input logic last);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        flush_i  = 1'b0;
        clear_i  = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid0) done = 1;
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d bytes still expected, required 0", name, exp_q.size());
        end
    endtask

    // Ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor.
    initial begin
        exp_t       e;
        bit         held = 0;
        logic [7:0] held0, held1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 0;
            end else begin
                if (held && out_valid0) begin
                    chk("hold_msb", {24'h0, out_data0}, {24'h0, held0});
                    chk("hold_lsb", {24'h0, out_data1}, {24'h0, held1});
                end
                held = 0;
                if (out_valid0) chk("in_ready_in_emit", {31'h0, in_ready0}, 32'h0);
                if (out_valid0 && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_out: got %h, required no output", out_data0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("msb_data", {24'h0, out_data0}, {24'h0, e.msb});
                        chk("lsb_data", {24'h0, out_data1}, {24'h0, e.lsb});
                        chk("msb_last", {31'h0, out_last0}, {31'h0, e.last});
                        chk("lsb_last", {31'h0, out_last1}, {31'h0, e.last});
                    end
                end else if (out_valid0) begin
                    held  = 1;
                    held0 = out_data0;
                    held1 = out_data1;
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string name);
        chk({name, "_in_ready"},  {31'h0, in_ready0},  32'h1);
        chk({name, "_out_valid"}, {31'h0, out_valid0}, 32'h0);
        chk({name, "_out_data"},  {24'h0, out_data0},  32'h0);
        chk({name, "_out_last"},  {31'h0, out_last0},  32'h0);
        chk({name, "_busy"},      {31'h0, busy0},      32'h0);
        chk({name, "_busy_lsb"},  {31'h0, busy1},      32'h0);
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        idle_inputs();
        #2;
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Empty message via flush.
        push_digest(32'h811C9DC5, 4);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        chk("flush_busy", {31'h0, busy0}, 32'h1);
        chk("flush_out_valid", {31'h0, out_valid0}, 32'h1);
        drain("empty");

        // "a"
        @(posedge clk);
        #1;
        push_digest(32'hE40C292C, 4);
        send_byte(8'h61, 1'b1);
        idle_inputs();
        chk("a_latency_data", {24'h0, out_data0}, 32'hE4);
        drain("a");

        // "foobar" back-to-back
        @(posedge clk);
        #1;
        push_digest(32'hBF9CF968, 4);
        send_byte(8'h66, 1'b0);
        chk("foobar_busy_mid", {31'h0, busy0}, 32'h1);
        send_byte(8'h6F, 1'b0);
        send_byte(8'h6F, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h61, 1'b0);
        send_byte(8'h72, 1'b1);
        // Junk offered during emit must not be absorbed.
        in_data = 8'h55;
        drain("foobar");
        idle_inputs();

        // "a" with random back-pressure
        rdy_mode = 1;
        @(posedge clk);
        #1;
        push_digest(32'hE40C292C, 4);
        send_byte(8'h61, 1'b1);
        idle_inputs();
        drain("a_random");
        rdy_mode = 0;
        @(posedge clk);
        #1;
        chk("a_random_absorb", {31'h0, in_ready0}, 32'h1);
        chk("a_random_idle", {31'h0, busy0}, 32'h0);

        // clear after "foo", then "a"
        send_byte(8'h66, 1'b0);
        send_byte(8'h6F, 1'b0);
        send_byte(8'h6F, 1'b0);
        in_valid = 1'b0;
        clear_i  = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        chk("clear_foo_busy", {31'h0, busy0}, 32'h0);
        push_digest(32'hE40C292C, 4);
        send_byte(8'h61, 1'b1);
        idle_inputs();
        drain("clear_then_a");

        // clear during emit at idx 2
        rdy_mode  = 2;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        push_digest(32'hE40C292C, 2);
        send_byte(8'h61, 1'b1);
        idle_inputs();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        clear_i   = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        chk("clear_emit_valid", {31'h0, out_valid0}, 32'h0);
        chk("clear_emit_busy", {31'h0, busy0}, 32'h0);
        chk("clear_emit_queue", exp_q.size(), 32'h0);
        rdy_mode = 0;
        @(posedge clk);
        #1;
        push_digest(32'hE40C292C, 4);
        send_byte(8'h61, 1'b1);
        idle_inputs();
        drain("after_clear_emit");

        // reset mid-"foobar"
        send_byte(8'h66, 1'b0);
        send_byte(8'h6F, 1'b0);
        send_byte(8'h6F, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        chk_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_digest(32'hE40C292C, 4);
        send_byte(8'h61, 1'b1);
        idle_inputs();
        drain("after_reset");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
